// File: rtl/axis_to_wb_pkg.sv
// Shared types and constants for the AXI-Stream to Wishbone write engine.
// Contents: FSM state encoding, full byte-select mask, bytes per bus word, data width.
package axis_to_wb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StFinish
   } state_e;

   localparam int unsigned   DATA_W     = 32;
   localparam logic [3:0]    SEL_ALL    = 4'hF;
   localparam logic [31:0]   WORD_BYTES = 32'd4;

endpackage

// File: rtl/axis_wb_fifo.sv
// Synchronous word FIFO buffering stream data ahead of the Wishbone writes.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high clear
//   push_i, data_i    write a word (ignored when full)
//   pop_i             drop the head word (ignored when empty)
//   full_o, empty_o   occupancy flags
//   head_o            oldest stored word
module axis_wb_fifo
   import axis_to_wb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [DATA_W-1:0] head_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic              do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/axis_to_wb_writer.sv
// Stream-to-memory write engine: buffers AXI-Stream words and writes each one to
// consecutive word addresses as a Wishbone classic single write.
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   start, base_addr, length   transfer request (sampled only when idle)
//   busy, done                 transfer status; done is a one-cycle pulse
//   err_early_last             tlast arrived before length words (sticky until start)
//   err_missing_last           length words arrived without tlast (sticky until start)
//   s_t*                       AXI-Stream slave
//   wbm_*                      Wishbone classic master (write only)
module axis_to_wb_writer
   import axis_to_wb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LEN_W      = 12
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              start,
   input  logic [31:0]       base_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic              err_early_last,
   output logic              err_missing_last,
   input  logic              s_tvalid,
   input  logic [31:0]       s_tdata,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic [31:0]       wbm_adr_o,
   output logic [31:0]       wbm_dat_o,
   input  logic              wbm_ack_i
);

   state_e            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  acc_cnt_q, acc_cnt_d;
   logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic              stb_q, stb_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       dat_q, dat_d;
   logic              busy_q, busy_d;
   logic              early_q, early_d;
   logic              missing_q, missing_d;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [31:0]       fifo_head;
   logic              accept;
   logic [LEN_W-1:0]  acc_next;

   axis_wb_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (fifo_push),
      .data_i  (s_tdata),
      .pop_i   (fifo_pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   assign s_tready = (state_q == StRun) && !fifo_full && (acc_cnt_q < len_q);
   assign accept   = s_tvalid && s_tready;
   assign acc_next = acc_cnt_q + LEN_W'(1);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      acc_cnt_d = acc_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      stb_d     = stb_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      busy_d    = busy_q;
      early_d   = early_q;
      missing_d = missing_q;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d    = base_addr & ~(WORD_BYTES - 32'd1);
               len_d     = length;
               acc_cnt_d = '0;
               wr_cnt_d  = '0;
               early_d   = 1'b0;
               missing_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = (length == '0) ? StFinish : StRun;
            end
         end
         StRun: begin
            if (accept) begin
               fifo_push = 1'b1;
               acc_cnt_d = acc_next;
               if (s_tlast && (acc_next < len_q)) begin
                  early_d = 1'b1;
                  state_d = StDrain;
               end else if (acc_next == len_q) begin
                  missing_d = !s_tlast;
                  state_d   = StDrain;
               end
            end
         end
         StDrain: begin
            if (fifo_empty && !stb_q) state_d = StFinish;
         end
         StFinish: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Write engine. stb always drops for a cycle after an ack, because the
      // memory side may ack combinationally and a held stb would write twice.
      if ((state_q == StRun) || (state_q == StDrain)) begin
         if (stb_q) begin
            if (wbm_ack_i) begin
               fifo_pop = 1'b1;
               addr_d   = addr_q + WORD_BYTES;
               wr_cnt_d = wr_cnt_q + LEN_W'(1);
               stb_d    = 1'b0;
            end
         end else if (!fifo_empty) begin
            stb_d = 1'b1;
            adr_d = addr_q;
            dat_d = fifo_head;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         len_q     <= '0;
         acc_cnt_q <= '0;
         wr_cnt_q  <= '0;
         stb_q     <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         busy_q    <= 1'b0;
         early_q   <= 1'b0;
         missing_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         acc_cnt_q <= acc_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         stb_q     <= stb_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         busy_q    <= busy_d;
         early_q   <= early_d;
         missing_q <= missing_d;
      end
   end

   assign busy             = busy_q;
   assign done             = (state_q == StFinish);
   assign err_early_last   = early_q;
   assign err_missing_last = missing_q;
   assign wbm_cyc_o        = stb_q;
   assign wbm_stb_o        = stb_q;
   assign wbm_we_o         = stb_q;
   assign wbm_sel_o        = stb_q ? SEL_ALL : 4'h0;
   assign wbm_adr_o        = adr_q;
   assign wbm_dat_o        = dat_q;

endmodule

// File: tb/tb_axis_to_wb_writer.sv
// Self-checking bench for axis_to_wb_writer: directed cases plus randomized
// transfers, checked against a transaction-level model of expected writes.
module tb_axis_to_wb_writer;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic [11:0] length;
   logic        busy, done, err_early_last, err_missing_last;
   logic        s_tvalid, s_tlast, s_tready;
   logic [31:0] s_tdata;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;

   int  n_cmp = 0;
   int  n_fail = 0;
   wr_t exp_q[$];
   wr_t log_q[$];
   int  acks_done = 0;
   bit  ack_now = 0;
   int  ack_delay = 0;
   bit  ack_noise = 0;
   bit  noise_bit = 0;
   int  stb_age = 0;
   logic        prev_stb = 0, prev_ack = 0;
   logic [31:0] prev_adr = 0, prev_dat = 0;

   always #5 clk = ~clk;

   axis_to_wb_writer #(
      .FIFO_DEPTH (DEPTH),
      .LEN_W      (12)
   ) dut (
      .wb_clk_i         (clk),
      .wb_rst_i         (rst),
      .start            (start),
      .base_addr        (base_addr),
      .length           (length),
      .busy             (busy),
      .done             (done),
      .err_early_last   (err_early_last),
      .err_missing_last (err_missing_last),
      .s_tvalid         (s_tvalid),
      .s_tdata          (s_tdata),
      .s_tlast          (s_tlast),
      .s_tready         (s_tready),
      .wbm_cyc_o        (wbm_cyc_o),
      .wbm_stb_o        (wbm_stb_o),
      .wbm_we_o         (wbm_we_o),
      .wbm_sel_o        (wbm_sel_o),
      .wbm_adr_o        (wbm_adr_o),
      .wbm_dat_o        (wbm_dat_o),
      .wbm_ack_i        (wbm_ack_i)
   );

   // Slave: ack after ack_delay cycles of strobe; optional junk ack while idle.
   assign wbm_ack_i = wbm_stb_o ? (stb_age >= ack_delay) : noise_bit;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (ack_now) acks_done++;
      stb_age <= (wbm_stb_o && !wbm_ack_i) ? stb_age + 1 : 0;
   end

   always @(negedge clk) noise_bit <= ack_noise && ($urandom_range(0, 1) == 1);

   // Bus monitor: protocol rules and write order against the expected queue.
   always @(negedge clk) begin
      if (rst) begin
         prev_stb = 0;
         prev_ack = 0;
         ack_now  = 0;
      end else begin
         chk("cyc_follows_stb", {31'd0, wbm_cyc_o}, {31'd0, wbm_stb_o});
         chk("we_follows_stb", {31'd0, wbm_we_o}, {31'd0, wbm_stb_o});
         chk("sel_follows_stb", {28'd0, wbm_sel_o}, wbm_stb_o ? 32'hF : 32'h0);
         if (prev_stb && !prev_ack) begin
            chk("stb_held", {31'd0, wbm_stb_o}, 32'd1);
            chk("adr_stable", wbm_adr_o, prev_adr);
            chk("dat_stable", wbm_dat_o, prev_dat);
         end
         if (prev_stb && prev_ack) chk("stb_gap_after_ack", {31'd0, wbm_stb_o}, 32'd0);
         ack_now = wbm_stb_o && wbm_ack_i;
         if (ack_now) begin
            log_q.push_back({wbm_adr_o, wbm_dat_o});
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 32'd1, 32'd0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("write_adr", wbm_adr_o, e.adr);
               chk("write_dat", wbm_dat_o, e.dat);
            end
         end
         prev_stb = wbm_stb_o;
         prev_ack = wbm_ack_i;
         prev_adr = wbm_adr_o;
         prev_dat = wbm_dat_o;
      end
   end

   // One transfer: words[i] carries tlast iff i == last_pos; dat0 != 0 gives dat0+i.
   task automatic run_transfer(input int len, input logic [31:0] base, input int nw,
                               input int last_pos, input logic [31:0] dat0, input bit gappy);
      logic [31:0] wd[$];
      bit          wl[$];
      int          k, acc, acks_base, occ;
      bit          early, missing, done_seen;
      for (int i = 0; i < nw; i++) begin
         wd.push_back((dat0 != 0) ? dat0 + 32'(i) : $urandom);
         wl.push_back(i == last_pos);
      end
      // Model: words accepted up to length or an early tlast, written in order.
      early   = (last_pos >= 0) && (last_pos + 1 < len);
      k       = early ? last_pos + 1 : len;
      missing = (len > 0) && !early && (last_pos != len - 1);
      for (int i = 0; i < k; i++)
         exp_q.push_back({(base & 32'hFFFF_FFFC) + 32'(4 * i), wd[i]});

      @(negedge clk);
      start = 1; base_addr = base; length = 12'(len);
      acks_base = acks_done;
      @(negedge clk);
      start = 0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      acc = 0;
      done_seen = 0;
      for (int c = 0; c < 3000; c++) begin
         if (done) begin
            done_seen = 1;
            break;
         end
         chk("busy_during", {31'd0, busy}, 32'd1);
         s_tvalid = (acc < nw) && (!gappy || $urandom_range(0, 3) != 0);
         s_tdata  = (acc < nw) ? wd[acc] : $urandom;
         s_tlast  = (acc < nw) ? wl[acc] : 1'b0;
         start    = ($urandom_range(0, 15) == 0);
         if (start) base_addr = $urandom;
         #1;
         occ = acc - (acks_done - acks_base);
         chk("s_tready", {31'd0, s_tready}, {31'd0, (acc < k) && (occ < DEPTH)});
         if (s_tvalid && s_tready) acc++;
         @(negedge clk);
      end
      s_tvalid = 0;
      start = 0;
      chk("done_seen", {31'd0, done_seen}, 32'd1);
      chk("words_accepted", 32'(acc), 32'(k));
      chk("err_early_last", {31'd0, err_early_last}, {31'd0, early});
      chk("err_missing_last", {31'd0, err_missing_last}, {31'd0, missing});
      chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acks_base;
      bit seen;
      rst = 1; start = 0; base_addr = 0; length = 0;
      s_tvalid = 0; s_tdata = 0; s_tlast = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err_early", {31'd0, err_early_last}, 32'd0);
      chk("rst_err_missing", {31'd0, err_missing_last}, 32'd0);
      chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
      chk("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
      chk("rst_adr", wbm_adr_o, 32'd0);
      chk("rst_dat", wbm_dat_o, 32'd0);
      rst = 0;

      // Zero-wait ack, normal frame.
      ack_delay = 0; log_q.delete();
      run_transfer(3, 32'h3800_0000, 3, 2, 32'hA0, 0);
      chk("t1_nwrites", 32'(log_q.size()), 32'd3);
      if (log_q.size() == 3) begin
         chk("t1_adr0", log_q[0].adr, 32'h3800_0000);
         chk("t1_adr2", log_q[2].adr, 32'h3800_0008);
         chk("t1_dat1", log_q[1].dat, 32'hA1);
      end

      // Early tlast on second word.
      log_q.delete();
      run_transfer(4, 32'h100, 4, 1, 32'hB0, 1);
      chk("t2_nwrites", 32'(log_q.size()), 32'd2);
      chk("t2_early", {31'd0, err_early_last}, 32'd1);

      // No tlast: third offered word must never be taken.
      log_q.delete();
      run_transfer(2, 32'h200, 3, -1, 32'hC0, 1);
      chk("t3_nwrites", 32'(log_q.size()), 32'd2);
      chk("t3_missing", {31'd0, err_missing_last}, 32'd1);

      // Slow ack with continuous stream fills the FIFO.
      ack_delay = 5; log_q.delete();
      run_transfer(8, 32'h4000, 8, 7, 32'hD0, 0);
      chk("t4_nwrites", 32'(log_q.size()), 32'd8);
      if (log_q.size() == 8) chk("t4_adr7", log_q[7].adr, 32'h401C);

      // Address wrap and low-bit masking.
      ack_delay = 1; log_q.delete();
      run_transfer(2, 32'hFFFF_FFFC, 2, 1, 32'hE0, 1);
      if (log_q.size() == 2) begin
         chk("t5_adr0", log_q[0].adr, 32'hFFFF_FFFC);
         chk("t5_adr_wrap", log_q[1].adr, 32'h0000_0000);
      end
      log_q.delete();
      run_transfer(1, 32'h1000_0003, 1, 0, 32'hF0, 0);
      if (log_q.size() == 1) chk("t5_adr_mask", log_q[0].adr, 32'h1000_0000);

      // Reset while a write is pending.
      ack_delay = 5;
      for (int i = 0; i < 8; i++)
         exp_q.push_back({32'h2000_0000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i)});
      @(negedge clk);
      start = 1; base_addr = 32'h2000_0000; length = 12'd8;
      @(negedge clk);
      start = 0;
      acks_base = acks_done;
      acc = 0;
      seen = 0;
      for (int c = 0; c < 200; c++) begin
         s_tvalid = (acc < 8);
         s_tdata  = 32'hC0DE_0000 + 32'(acc);
         s_tlast  = (acc == 7);
         #1;
         if (s_tvalid && s_tready) acc++;
         if (wbm_stb_o && (acks_done - acks_base >= 2)) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      chk("rst_test_reached_stb", {31'd0, seen}, 32'd1);
      s_tvalid = 0;
      @(posedge clk); #2 rst = 1;
      @(posedge clk); #2 rst = 0;
      exp_q.delete();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_mid_stb", {31'd0, wbm_stb_o}, 32'd0);
         chk("rst_mid_busy", {31'd0, busy}, 32'd0);
         chk("rst_mid_done", {31'd0, done}, 32'd0);
      end
      run_transfer(0, 32'h5000, 0, -1, 0, 0);

      // Randomized transfers.
      for (int t = 0; t < 40; t++) begin
         int len, lp, nw;
         len = $urandom_range(0, 10);
         nw  = len + $urandom_range(0, 2);
         case ($urandom_range(0, 3))
            0:       lp = -1;
            1:       lp = (len > 0) ? $urandom_range(0, len - 1) : -1;
            default: lp = len - 1;
         endcase
         ack_delay = $urandom_range(0, 3);
         ack_noise = ($urandom_range(0, 1) == 1);
         run_transfer(len, $urandom, nw, lp, 0, 1);
      end
      ack_noise = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_to_wb_writer.md
Name: axis_to_wb_writer

Overview:
- Stream-to-memory write engine: the writer counterpart of the existing Wishbone-read → AXI-Stream path that feeds the FIR/MM engine.
- Accepts FIR/MM result words on an AXI-Stream slave (sm_* side), buffers them, and writes them to SDRAM as Wishbone classic single writes through the arbiter's DMA port.
- Programmed by a start pulse with base address and word count; reports done/busy and framing errors.

Parameters:
- FIFO_DEPTH, 4, stream buffer depth in words (power of 2, ≥2)
- LEN_W, 12, width of word-count field (max transfer 2^LEN_W−1 words)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- base_addr  in  32  byte address of first word; bits[1:0] ignored (forced 0)
- length  in  LEN_W  number of 32-bit words to write
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of transfer
- err_early_last  out  1  sticky until next start: tlast arrived before word length
- err_missing_last  out  1  sticky until next start: word length arrived without tlast
- s_tvalid  in  1  stream data valid
- s_tdata  in  32  stream data
- s_tlast  in  1  last word of frame
- s_tready  out  1  writer can accept
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  always 1 while stb high, else 0
- wbm_sel_o  out  4  4'hF while stb high, else 4'h0
- wbm_adr_o  out  32  write address
- wbm_dat_o  out  32  write data (FIFO head)
- wbm_ack_i  in  1  write acknowledge (may be combinational from stb)

Behaviour:
- Reset (sync, wb_rst_i high at edge): state IDLE, FIFO emptied, all outputs 0 (busy, done, err_*, s_tready, cyc, stb, we, sel, adr, dat); a transfer in flight is abandoned, with no done pulse.
- FSM states: IDLE, RUN, DRAIN, FINISH.
- IDLE: on start, latch addr={base_addr[31:2],2'b00}, clear err_*, zero acc_cnt and wr_cnt, set busy. If length==0, go to FINISH directly. Otherwise go to RUN.
- RUN: s_tready = !fifo_full && (acc_cnt < length). No combinational bypass: push and pop may coincide, but readiness uses full only.
- Stream handshake: on s_tvalid&&s_tready, push s_tdata and increment acc_cnt.
  - s_tlast on word with acc_cnt+1 < length: set err_early_last, stop accepting, go to DRAIN.
  - Word with acc_cnt+1 == length and !s_tlast: set err_missing_last, go to DRAIN.
  - Word with acc_cnt+1 == length and s_tlast: normal, go to DRAIN.
- DRAIN: s_tready=0; continue writes until FIFO empty, then go to FINISH.
- Write engine (RUN and DRAIN):
  - When FIFO non-empty and stb low and no ack-recovery cycle pending: next cycle raise cyc/stb/we, sel=F, adr=addr, dat=FIFO head.
  - Hold all write signals stable until wbm_ack_i. On the ack cycle: pop FIFO, addr+=4 (wraps mod 2^32), wr_cnt++.
  - Next cycle: cyc/stb drop for ≥1 cycle. This is mandatory because the SDRAM path acks writes combinationally, so holding stb would double-write.
  - wbm_ack_i while stb low is ignored.
- Latency: word accepted at edge N → stb high in cycle N+1 if the engine is idle. Back-to-back writes with zero-wait ack occupy 2 cycles per word.
- FINISH: one-cycle done=1, busy=0 at the following edge, return to IDLE. A start asserted during busy is ignored; no queueing.
- Every accepted word is eventually written, so wr_cnt == acc_cnt at done.

Decomposition:
- Package axis_to_wb_pkg: state enum (IDLE, RUN, DRAIN, FINISH), SEL_ALL=4'hF, WORD_BYTES=4.
- One sub-module: axis_wb_fifo (sync FIFO, FIFO_DEPTH, push/pop/full/empty/head, sync clear on reset).

Test Plan:
- length=3, base=0x3800_0000, stream A0,A1,A2 with tlast on A2, ack same cycle as stb → writes 0x38000000/4/8 with A0..A2, stb low between writes, done once, errs 0.
- length=4, tlast on 2nd word → 2 writes only, err_early_last=1, done pulses, s_tready 0 after 2nd word.
- length=2, no tlast → 2 writes, err_missing_last=1, third stream word never accepted (s_tready=0).
- ack delayed 5 cycles per write, 8 words streamed continuously, FIFO_DEPTH=4 → s_tready drops when 4 buffered, adr/dat stable while stb waits, all 8 written in order.
- base=0xFFFF_FFFC, length=2 → addresses 0xFFFFFFFC then 0x00000000; base=0x...3 → first adr low bits 00.
- wb_rst_i asserted while stb high mid-transfer → next cycle cyc/stb/busy 0, no done; new start with length=0 → done next-but-one cycle, no bus activity.
